// File: rtl/alt_sched_pkg.sv
// Shared types and counter widths for the alternating-run detector scheduler.
// Widths cover the largest legal RUN_LEN (15) and MAX_BITS (255).
package alt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } state_t;

  localparam int RUN_W = 4;
  localparam int BIT_W = 8;

endpackage

// File: rtl/alt_run_detect.sv
// Shared alternating-run detector: counts consecutive samples that differ from
// the previous one; an equal sample (or the first sample of a job) restarts at 1.
module alt_run_detect
  import alt_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic             data_bit,
  output logic [RUN_W-1:0] run_cnt
);

  logic prev_bit;

  // A zero count marks "no sample yet this job", so no separate first-sample flag is needed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run_cnt  <= '0;
      prev_bit <= 1'b0;
    end else if (valid) begin
      prev_bit <= data_bit;
      if (run_cnt == '0 || data_bit == prev_bit) begin
        run_cnt <= RUN_W'(1);
      end else begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/alt_detect_sched.sv
// Round-robin scheduler sharing one alternating-run detector among NUM_CH serial channels.
// Optional feature: define ALT_SCHED_STATS_EN to enable the saturating match_total counter.
module alt_detect_sched
  import alt_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int RUN_LEN  = 4,
  parameter int MAX_BITS = 16,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] gnt,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              timeout,
  output logic [CH_W-1:0]   done_ch,
  output logic [7:0]        match_total
);

  state_t           state;
  logic [CH_W-1:0]  gidx;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  pick;
  logic [CH_W-1:0]  next_ptr;
  logic [BIT_W-1:0] bit_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic             cur_req;
  logic             cur_din;
  logic             hit_match;
  logic             hit_to;
  logic             valid;
  logic             clear;

  // Walk offsets from the top down so the requester closest after rr_ptr wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (req[idx]) pick = CH_W'(idx);
    end
  end

  assign cur_req   = req[gidx];
  assign cur_din   = din[gidx];
  assign next_ptr  = (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + CH_W'(1);
  assign hit_match = (run_cnt == RUN_W'(RUN_LEN));
  assign hit_to    = (bit_cnt == BIT_W'(MAX_BITS));
  assign valid     = (state == RUN) && cur_req && !hit_match && !hit_to;
  assign clear     = (state != RUN) || !cur_req;

  alt_run_detect u_detect (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .valid    (valid),
    .data_bit (cur_din),
    .run_cnt  (run_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_cnt <= '0;
    end else if (valid) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Terminal conditions are judged on the registered counters, one cycle after the deciding sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gidx    <= '0;
      rr_ptr  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      match   <= 1'b0;
      timeout <= 1'b0;
      done_ch <= '0;
    end else begin
      done    <= 1'b0;
      match   <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state <= RUN;
            gidx  <= pick;
            gnt   <= NUM_CH'(1) << pick;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!cur_req) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end else if (hit_match || hit_to) begin
            state   <= REPORT;
            gnt     <= '0;
            done    <= 1'b1;
            match   <= hit_match;
            timeout <= !hit_match;
            done_ch <= gidx;
            rr_ptr  <= next_ptr;
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      match_total <= '0;
    end else if (state == RUN && cur_req && hit_match && match_total != 8'hFF) begin
      match_total <= match_total + 8'd1;
    end
  end
`else
  assign match_total = '0;
`endif

endmodule

// File: tb/tb_alt_detect_sched.sv
// Self-checking bench for alt_detect_sched: directed jobs with literal expectations
// plus randomized traffic checked every cycle against a job-level queue model.
module tb_alt_detect_sched;

  localparam int NUM_CH   = 4;
  localparam int RUN_LEN  = 4;
  localparam int MAX_BITS = 16;
  localparam int CH_W     = $clog2(NUM_CH);
`ifdef ALT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] req = '0;
  logic [NUM_CH-1:0] din = '0;
  logic [NUM_CH-1:0] gnt;
  logic              busy;
  logic              done;
  logic              match;
  logic              timeout;
  logic [CH_W-1:0]   done_ch;
  logic [7:0]        match_total;

  int checks = 0;
  int errors = 0;

  // Reference model state: channel being served (-1 none), samples taken this job,
  // and the one-cycle report that follows a finished job.
  int m_ch       = -1;
  int m_report   = 0;
  int m_rep_ch   = 0;
  int m_rep_m    = 0;
  int m_done_ch  = 0;
  int m_ptr      = 0;
  int m_total    = 0;
  int q[$];

  always #5 clk = ~clk;

  alt_detect_sched #(
    .NUM_CH   (NUM_CH),
    .RUN_LEN  (RUN_LEN),
    .MAX_BITS (MAX_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .din         (din),
    .gnt         (gnt),
    .busy        (busy),
    .done        (done),
    .match       (match),
    .timeout     (timeout),
    .done_ch     (done_ch),
    .match_total (match_total)
  );

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Length of the alternating tail of the sample history.
  function automatic int trailingAlt();
    int r;
    if (q.size() == 0) return 0;
    r = 1;
    for (int i = q.size() - 1; i >= 1; i--) begin
      if (q[i] != q[i-1]) r++;
      else break;
    end
    return r;
  endfunction

  task automatic finishJob(input int is_match);
    m_report  = 1;
    m_rep_ch  = m_ch;
    m_rep_m   = is_match;
    m_done_ch = m_ch;
    m_ptr     = (m_ch + 1) % NUM_CH;
    m_ch      = -1;
    q.delete();
    if (is_match != 0 && STATS && m_total < 255) m_total++;
  endtask

  task automatic modelStep();
    if (rst) begin
      m_ch = -1; m_report = 0; m_rep_ch = 0; m_rep_m = 0;
      m_done_ch = 0; m_ptr = 0; m_total = 0;
      q.delete();
    end else if (m_report != 0) begin
      m_report = 0;
    end else if (m_ch >= 0) begin
      if (!req[m_ch]) begin
        m_ptr = (m_ch + 1) % NUM_CH;
        m_ch  = -1;
        q.delete();
      end else if (trailingAlt() >= RUN_LEN) begin
        finishJob(1);
      end else if (q.size() >= MAX_BITS) begin
        finishJob(0);
      end else begin
        q.push_back(int'(din[m_ch]));
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (req[(m_ptr + k) % NUM_CH]) begin
          m_ch = (m_ptr + k) % NUM_CH;
          break;
        end
      end
    end
  endtask

  task automatic checkOutput();
    int exp_gnt;
    exp_gnt = (m_ch >= 0) ? (1 << m_ch) : 0;
    cmp("gnt", int'(gnt), exp_gnt);
    cmp("busy", int'(busy), int'(m_ch >= 0 || m_report != 0));
    cmp("done", int'(done), m_report);
    cmp("match", int'(match), int'(m_report != 0 && m_rep_m != 0));
    cmp("timeout", int'(timeout), int'(m_report != 0 && m_rep_m == 0));
    cmp("done_ch", int'(done_ch), m_done_ch);
    cmp("match_total", int'(match_total), m_total);
  endtask

  always @(posedge clk) begin
    modelStep();
    #1;
    checkOutput();
  end

  function automatic logic patBit(input int mode, input int k);
    if (mode == 0) return (k % 2 == 0);
    return (k % 3 != 2);
  endfunction

  // Runs one job: requests, waits for the grant, feeds a pattern, reports latency from grant to done.
  task automatic applyStimulus(input logic [NUM_CH-1:0] reqv, input int mode,
                               input int dropAfter, input int rstAfter,
                               output int gch, output int lat,
                               output logic m, output logic t, output int dch);
    gch = -1; lat = -1; m = 1'b0; t = 1'b0; dch = -1;
    @(negedge clk);
    req = reqv;
    din = '0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    if (gnt == '0) return;
    for (int i = 0; i < NUM_CH; i++) if (gnt[i]) gch = i;
    for (int k = 0; k < 40; k++) begin
      din = {NUM_CH{patBit(mode, k)}};
      if (dropAfter >= 0 && k == dropAfter) req = reqv & ~(NUM_CH'(1) << gch);
      if (rstAfter >= 0 && k == rstAfter) rst = 1'b1;
      @(negedge clk);
      if (done) begin
        lat = k + 1; m = match; t = timeout; dch = int'(done_ch);
        break;
      end
      if (dropAfter >= 0 && k >= dropAfter + 3) break;
      if (rstAfter >= 0 && k >= rstAfter + 3) break;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int gch, lat, dch;
    logic m, t;
    rst = 1'b1; req = '0; din = '0;
    repeat (3) @(negedge clk);
    cmp("reset_gnt", int'(gnt), 0);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_total", int'(match_total), 0);
    rst = 1'b0;

    applyStimulus(4'b0001, 0, -1, -1, gch, lat, m, t, dch);
    req = '0;
    cmp("alt_grant_ch", gch, 0);
    cmp("alt_latency", lat, 5);
    cmp("alt_match", int'(m), 1);
    cmp("alt_timeout", int'(t), 0);
    cmp("alt_done_ch", dch, 0);
    cmp("alt_total", int'(match_total), STATS ? 1 : 0);

    applyStimulus(4'b0001, 1, -1, -1, gch, lat, m, t, dch);
    req = '0;
    cmp("to_latency", lat, 17);
    cmp("to_timeout", int'(t), 1);
    cmp("to_match", int'(m), 0);

    doReset();
    for (int j = 0; j < 5; j++) begin
      applyStimulus(4'b1111, 0, -1, -1, gch, lat, m, t, dch);
      cmp("rr_order", gch, j % NUM_CH);
      cmp("rr_latency", lat, 5);
      cmp("rr_match", int'(m), 1);
    end
    req = '0;

    applyStimulus(4'b0010, 0, 2, -1, gch, lat, m, t, dch);
    req = '0;
    cmp("abort_grant_ch", gch, 1);
    cmp("abort_no_done", lat, -1);
    @(negedge clk);
    cmp("abort_idle", int'(busy), 0);
    applyStimulus(4'b0011, 0, -1, -1, gch, lat, m, t, dch);
    req = '0;
    cmp("abort_next_grant", gch, 0);
    cmp("abort_next_latency", lat, 5);

    applyStimulus(4'b0001, 0, -1, 2, gch, lat, m, t, dch);
    req = '0;
    cmp("rst_no_done", lat, -1);
    cmp("rst_gnt", int'(gnt), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_done", int'(done), 0);
    cmp("rst_match", int'(match), 0);
    rst = 1'b0;

    for (int n = 0; n < (STATS ? 300 : 5); n++) begin
      applyStimulus(4'b0001, 0, -1, -1, gch, lat, m, t, dch);
      req = '0;
    end
    cmp("stats_total", int'(match_total), STATS ? 255 : 0);

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = NUM_CH'($urandom);
      din = NUM_CH'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
